// File: rtl/benes_cfg_loader_if.sv
// Configuration beat channel for the Benes switch loader.
// Valid/ready handshake; one stage's worth of switch controls per beat.
interface benes_cfg_loader_if #(
  parameter int SW         = 3,
  parameter int SWITCH_NUM = 4
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [SW-1:0]         cfg_stage;
  logic [SWITCH_NUM-1:0] cfg_bits;
  logic                  cfg_last;

  modport master (
    output cfg_valid, cfg_stage, cfg_bits, cfg_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_stage, cfg_bits, cfg_last,
    output cfg_ready
  );
endinterface

// File: rtl/benes_cfg_loader.sv
// Collects a full per-stage switch configuration into a shadow store, then on frame_start
// rolls it into the live controls one stage per cycle so each data word sees one consistent setting.
module benes_cfg_loader #(
  parameter int SIZE       = 8,
  parameter int SWITCH_NUM = SIZE / 2,
  parameter int STAGE_NUM  = 2 * $clog2(SIZE) - 1
) (
  input  logic                            clk,
  input  logic                            rst,
  benes_cfg_loader_if.slave               cfg,
  input  logic                            frame_start,
  output logic [STAGE_NUM*SWITCH_NUM-1:0] sw_ctrl,
  output logic                            applied,
  output logic                            err_range,
  output logic                            err_incomplete
);
  localparam int            SW         = $clog2(STAGE_NUM);
  localparam logic [SW-1:0] LAST_STAGE = SW'(STAGE_NUM - 1);

  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

  state_t                state;
  logic [SWITCH_NUM-1:0] shadow [STAGE_NUM];
  logic [STAGE_NUM-1:0]  mask;
  logic [STAGE_NUM-1:0]  beat_bit;
  logic [STAGE_NUM-1:0]  mask_next;
  logic [SW-1:0]         skew;
  logic                  accept;
  logic                  in_range;

  always_comb begin
    accept    = cfg.cfg_valid && cfg.cfg_ready;
    in_range  = (cfg.cfg_stage <= LAST_STAGE);
    beat_bit  = in_range ? (STAGE_NUM'(1) << cfg.cfg_stage) : '0;
    mask_next = mask | beat_bit;
  end

  // Shadow contents are only trusted where the mask says so, hence no reset.
  always_ff @(posedge clk) begin
    if (accept && in_range) begin
      shadow[cfg.cfg_stage] <= cfg.cfg_bits;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      mask           <= '0;
      skew           <= '0;
      sw_ctrl        <= '0;
      applied        <= 1'b0;
      err_range      <= 1'b0;
      err_incomplete <= 1'b0;
      cfg.cfg_ready  <= 1'b0;
    end else begin
      applied        <= 1'b0;
      err_range      <= 1'b0;
      err_incomplete <= 1'b0;
      case (state)
        IDLE: begin
          cfg.cfg_ready <= 1'b1;
          if (accept) begin
            err_range <= !in_range;
            if (cfg.cfg_last) begin
              // An out-of-range closing beat spoils the set even if the mask is full.
              if (in_range && (&mask_next)) begin
                state         <= PENDING;
                mask          <= mask_next;
                cfg.cfg_ready <= 1'b0;
              end else begin
                err_incomplete <= 1'b1;
                mask           <= '0;
              end
            end else begin
              mask <= mask_next;
            end
          end
        end
        PENDING: begin
          cfg.cfg_ready <= 1'b0;
          if (frame_start) begin
            sw_ctrl[SWITCH_NUM-1:0] <= shadow[0];
            skew                    <= SW'(1);
            state                   <= APPLY;
          end
        end
        APPLY: begin
          sw_ctrl[int'(skew)*SWITCH_NUM +: SWITCH_NUM] <= shadow[skew];
          if (skew == LAST_STAGE) begin
            skew          <= '0;
            state         <= IDLE;
            mask          <= '0;
            applied       <= 1'b1;
            cfg.cfg_ready <= 1'b1;
          end else begin
            skew <= skew + SW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_benes_cfg_loader.sv
// Bench for benes_cfg_loader at SIZE=8: scoreboard of expected pulse cycles and applied values.
module tb_benes_cfg_loader;
  localparam int STAGE_NUM  = 5;
  localparam int SWITCH_NUM = 4;
  localparam int SW         = 3;
  localparam int W          = STAGE_NUM * SWITCH_NUM;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         frame_start = 1'b0;
  logic [W-1:0] sw_ctrl;
  logic         applied;
  logic         err_range;
  logic         err_incomplete;

  always #5 clk = ~clk;

  benes_cfg_loader_if #(.SW(SW), .SWITCH_NUM(SWITCH_NUM)) cfg_if ();

  benes_cfg_loader #(.SIZE(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg            (cfg_if),
    .frame_start    (frame_start),
    .sw_ctrl        (sw_ctrl),
    .applied        (applied),
    .err_range      (err_range),
    .err_incomplete (err_incomplete)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int           q_range[$];
  int           q_inc[$];
  int           q_apply_cyc[$];
  logic [W-1:0] q_apply_sw[$];

  logic [SWITCH_NUM-1:0] m_shadow [STAGE_NUM];
  logic [STAGE_NUM-1:0]  m_mask;
  logic [W-1:0]          exp_sw;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses are expected in the cycle after the accepting edge.
  always @(negedge clk) begin
    if (err_range) begin
      if (q_range.size() == 0) chk("err_range_unexpected", err_range, 0);
      else chk("err_range_cycle", cyc, q_range.pop_front());
    end
    if (err_incomplete) begin
      if (q_inc.size() == 0) chk("err_incomplete_unexpected", err_incomplete, 0);
      else chk("err_incomplete_cycle", cyc, q_inc.pop_front());
    end
    if (applied) begin
      if (q_apply_cyc.size() == 0) chk("applied_unexpected", applied, 0);
      else begin
        chk("applied_cycle", cyc, q_apply_cyc.pop_front());
        chk("applied_sw_ctrl", sw_ctrl, q_apply_sw.pop_front());
      end
    end
  end

  task automatic send_beat(input logic [SW-1:0] stage, input logic [SWITCH_NUM-1:0] bits,
                           input bit last);
    int waited = 0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_stage = stage;
    cfg_if.cfg_bits  = bits;
    cfg_if.cfg_last  = last;
    while (!cfg_if.cfg_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!cfg_if.cfg_ready) begin
      chk("ready_timeout", cfg_if.cfg_ready, 1);
    end else begin
      if (int'(stage) >= STAGE_NUM) begin
        q_range.push_back(cyc + 1);
        if (last) begin
          q_inc.push_back(cyc + 1);
          m_mask = '0;
        end
      end else begin
        m_shadow[stage] = bits;
        m_mask[stage]   = 1'b1;
        if (last && !(&m_mask)) begin
          q_inc.push_back(cyc + 1);
          m_mask = '0;
        end
      end
      tick();
    end
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_last  = 1'b0;
  endtask

  task automatic apply_set(input bit fs_mid);
    logic [W-1:0] final_sw;
    for (int s = 0; s < STAGE_NUM; s++) final_sw[s*SWITCH_NUM +: SWITCH_NUM] = m_shadow[s];
    q_apply_cyc.push_back(cyc + STAGE_NUM);
    q_apply_sw.push_back(final_sw);
    frame_start = 1'b1;
    for (int s = 0; s < STAGE_NUM; s++) begin
      tick();
      frame_start = fs_mid && (s == 1);
      exp_sw[s*SWITCH_NUM +: SWITCH_NUM] = m_shadow[s];
      chk($sformatf("sw_ctrl_skew%0d", s), sw_ctrl, exp_sw);
      chk($sformatf("applied_skew%0d", s), applied, (s == STAGE_NUM - 1));
      chk($sformatf("ready_skew%0d", s), cfg_if.cfg_ready, (s == STAGE_NUM - 1));
    end
    frame_start = 1'b0;
    m_mask = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_stage = '0;
    cfg_if.cfg_bits  = '0;
    cfg_if.cfg_last  = 1'b0;
    m_mask = '0;
    exp_sw = '0;
    for (int s = 0; s < STAGE_NUM; s++) m_shadow[s] = '0;

    // Reset values and release.
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_sw_ctrl", sw_ctrl, 0);
    chk("rst_ready", cfg_if.cfg_ready, 0);
    chk("rst_applied", applied, 0);
    chk("rst_err_range", err_range, 0);
    chk("rst_err_incomplete", err_incomplete, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", cfg_if.cfg_ready, 1);

    // Full set of 4'hF, held until frame_start; a mid-apply frame_start is ignored.
    for (int s = 0; s < STAGE_NUM; s++) send_beat(SW'(s), 4'hF, s == STAGE_NUM - 1);
    chk("ready_pending", cfg_if.cfg_ready, 0);
    repeat (2) tick();
    chk("sw_held_pending", sw_ctrl, exp_sw);
    apply_set(1'b1);
    chk("sw_all_cross", sw_ctrl, 20'hFFFFF);

    // Stage 2 missing: incomplete set, later frame_start does nothing.
    send_beat(3'd0, 4'h7, 1'b0);
    send_beat(3'd1, 4'h7, 1'b0);
    send_beat(3'd3, 4'h7, 1'b0);
    send_beat(3'd4, 4'h7, 1'b1);
    chk("err_incomplete_pulse", err_incomplete, 1);
    chk("ready_after_incomplete", cfg_if.cfg_ready, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (STAGE_NUM + 1) tick();
    chk("sw_after_incomplete", sw_ctrl, exp_sw);
    chk("ready_idle_after_incomplete", cfg_if.cfg_ready, 1);

    // Out-of-range beat dropped, stage 2 overwritten, frame_start alongside cfg_last ignored.
    send_beat(3'd0, 4'h1, 1'b0);
    send_beat(3'd1, 4'h2, 1'b0);
    send_beat(3'd2, 4'h3, 1'b0);
    send_beat(3'd5, 4'hF, 1'b0);
    chk("err_range_pulse", err_range, 1);
    send_beat(3'd2, 4'hA, 1'b0);
    send_beat(3'd3, 4'h4, 1'b0);
    frame_start = 1'b1;
    send_beat(3'd4, 4'h5, 1'b1);
    frame_start = 1'b0;
    repeat (3) tick();
    chk("sw_not_applied_same_cycle", sw_ctrl, exp_sw);
    chk("ready_pending2", cfg_if.cfg_ready, 0);
    apply_set(1'b0);
    chk("field2_last_wins", sw_ctrl[11:8], 4'hA);
    chk("sw_mixed_set", sw_ctrl, 20'h54A21);

    // Out-of-range beat carrying cfg_last spoils an otherwise full mask.
    for (int s = 0; s < STAGE_NUM; s++) send_beat(SW'(s), 4'h0, 1'b0);
    send_beat(3'd6, 4'h0, 1'b1);
    chk("range_last_err_range", err_range, 1);
    chk("range_last_err_incomplete", err_incomplete, 1);

    // Reset in the middle of an apply.
    for (int s = 0; s < STAGE_NUM; s++) send_beat(SW'(s), 4'h5, s == STAGE_NUM - 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    exp_sw[3:0] = 4'h5;
    chk("abort_skew0", sw_ctrl, exp_sw);
    tick();
    exp_sw[7:4] = 4'h5;
    chk("abort_skew1", sw_ctrl, exp_sw);
    rst = 1'b1;
    tick();
    exp_sw = '0;
    m_mask = '0;
    chk("abort_sw_cleared", sw_ctrl, exp_sw);
    chk("abort_ready_low", cfg_if.cfg_ready, 0);
    chk("abort_applied", applied, 0);
    rst = 1'b0;
    tick();
    chk("abort_ready_back", cfg_if.cfg_ready, 1);
    repeat (STAGE_NUM + 2) tick();
    chk("abort_sw_stays_zero", sw_ctrl, exp_sw);

    chk("range_queue_left", q_range.size(), 0);
    chk("incomplete_queue_left", q_inc.size(), 0);
    chk("apply_queue_left", q_apply_cyc.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
